// File: rtl/clock_mon_pkg.sv
// Shared types and default constants for the clock period monitor.
package clock_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    LOST    = 2'd3
  } mon_state_e;

  localparam int DEF_EXPECTED_DIV = 4;
  localparam int DEF_TOL          = 0;
  localparam int DEF_LOCK_COUNT   = 4;
  localparam int DEF_TIMEOUT      = 64;
  localparam int DEF_CNT_W        = 16;

  // Lower match bound never drops below one cycle.
  function automatic int match_lo(input int expected, input int tol);
    return (expected - tol < 1) ? 1 : expected - tol;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous input plus a history flop
// feeding a rising-edge detector.
module sync_edge_detect (
  input  logic clock_in,
  input  logic reset_n,
  input  logic async_in,
  output logic rise
);

  // [0],[1] synchronizer stages, [2] previous synchronized value
  logic [2:0] sync_q;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], async_in};
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/clock_period_monitor.sv
// Measures the period of a divided clock in clock_in cycles, tracks lock to
// the expected period and flags loss of the divided clock.
module clock_period_monitor
  import clock_mon_pkg::*;
#(
  parameter int EXPECTED_DIV = DEF_EXPECTED_DIV,
  parameter int TOL          = DEF_TOL,
  parameter int LOCK_COUNT   = DEF_LOCK_COUNT,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             clock_div,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             clock_lost
);

  localparam int MC_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LO_B    = CNT_W'(match_lo(EXPECTED_DIV, TOL));
  localparam logic [CNT_W-1:0] HI_B    = CNT_W'(EXPECTED_DIV + TOL);
  localparam logic [CNT_W-1:0] TO_B    = CNT_W'(TIMEOUT);
  // A timeout beyond the saturated counter range can never fire.
  localparam bit TO_REACH = (longint'(TIMEOUT) <= ((longint'(1) << CNT_W) - 1));
  localparam logic [MC_W-1:0] LC_B   = MC_W'(LOCK_COUNT);
  localparam logic [MC_W-1:0] MC_ONE = MC_W'(1);

  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic             match, timeout;
  mon_state_e       state_q, state_d;
  logic [MC_W-1:0]  mc_q, mc_d, mc_inc;
  logic             pv_d;

  sync_edge_detect u_sync (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .async_in (clock_div),
    .rise     (rise)
  );

  // Cycles since the last rise, holding at the top of its range.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)           cnt <= '0;
    else if (rise)          cnt <= CNT_ONE;
    else if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
  end

  assign match   = (cnt >= LO_B) && (cnt <= HI_B);
  assign timeout = TO_REACH && (cnt == TO_B);
  assign mc_inc  = mc_q + MC_ONE;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      mc_q         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      mc_q         <= mc_d;
      period_valid <= pv_d;
      if (pv_d) period <= cnt;
    end
  end

  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    pv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // First interval is partial, so it is never reported.
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          pv_d = 1'b1;
          if (match) begin
            mc_d = mc_inc;
            if (mc_inc == LC_B) state_d = LOCKED;
          end else begin
            mc_d = '0;
          end
        end
      end
      LOCKED: begin
        if (rise) begin
          pv_d = 1'b1;
          if (!match) begin
            mc_d    = '0;
            state_d = MEASURE;
          end
        end
      end
      LOST: begin
        if (rise) begin
          mc_d    = '0;
          state_d = MEASURE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A rise in the timeout cycle takes priority over the timeout.
    if (!rise && timeout && (state_q != LOST)) begin
      state_d = LOST;
      mc_d    = '0;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign clock_lost = (state_q == LOST);

endmodule

// File: tb/tb_clock_period_monitor.sv
// Bench for clock_period_monitor: three parameterizations, directed tables,
// hand sequences for lost/reset corners and a randomized model comparison.
module tb_clock_period_monitor;

  localparam int E  = 4;
  localparam int LC = 4;
  localparam int TO = 64;
  localparam int RA = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  cdiv = '0;
  logic [15:0] per0, per1;
  logic [3:0]  per2;
  logic [2:0]  pv, lk, lost;

  clock_period_monitor u0 (
    .clock_in(clk), .reset_n(rst_n), .clock_div(cdiv[0]),
    .period(per0), .period_valid(pv[0]), .locked(lk[0]), .clock_lost(lost[0]));

  clock_period_monitor #(.TOL(1)) u1 (
    .clock_in(clk), .reset_n(rst_n), .clock_div(cdiv[1]),
    .period(per1), .period_valid(pv[1]), .locked(lk[1]), .clock_lost(lost[1]));

  clock_period_monitor #(.CNT_W(4), .TIMEOUT(64)) u2 (
    .clock_in(clk), .reset_n(rst_n), .clock_div(cdiv[2]),
    .period(per2), .period_valid(pv[2]), .locked(lk[2]), .clock_lost(lost[2]));

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  int last_pv = 0;
  bit [2:0] rise_at [0:RA-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d (0x%0h) expected %0d (0x%0h)", nm, cyc, act, act, exp, exp);
  endtask

  // ---------------- reference model ----------------
  // Rise events are the cycles at which the bench's own clock_div edges
  // become visible; everything else follows from elapsed-time arithmetic.
  typedef struct {
    int refc;   // cycles elapsed at edge e are e-1-refc
    bit seen;
    bit lost_m;
    int streak;
    int period;
    bit pv_m;
    bit lk_m;
  } mdl_t;

  mdl_t m0, m1, m2;

  function automatic mdl_t mreset(input int refc);
    mdl_t s;
    s = '{refc: refc, seen: 0, lost_m: 0, streak: 0, period: 0, pv_m: 0, lk_m: 0};
    return s;
  endfunction

  function automatic mdl_t step(input mdl_t s, input bit r, input int e,
                                input int tol, input int maxc);
    int c, lo;
    c  = e - 1 - s.refc;
    if (c > maxc) c = maxc;
    lo = (E - tol < 1) ? 1 : E - tol;
    s.pv_m = 1'b0;
    if (r) begin
      if (s.seen && !s.lost_m) begin
        s.period = c;
        s.pv_m   = 1'b1;
        if (c >= lo && c <= E + tol) s.streak++;
        else s.streak = 0;
        s.lk_m = (s.streak >= LC);
      end
      s.lost_m = 1'b0;
      s.seen   = 1'b1;
      s.refc   = e - 1;
    end else if (!s.lost_m && c == TO) begin
      s.lost_m = 1'b1;
      s.lk_m   = 1'b0;
      s.streak = 0;
    end
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= mreset(cyc + 1);
      m1 <= mreset(cyc + 1);
      m2 <= mreset(cyc + 1);
    end else begin
      m0 <= step(m0, rise_at[(cyc+1) % RA][0], cyc + 1, 0, 65535);
      m1 <= step(m1, rise_at[(cyc+1) % RA][1], cyc + 1, 1, 65535);
      m2 <= step(m2, rise_at[(cyc+1) % RA][2], cyc + 1, 0, 15);
    end
  end

  function automatic int pk(input int p, input bit v, input bit l, input bit o);
    return (p << 3) | (int'(v) << 2) | (int'(l) << 1) | int'(o);
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model0", pk(int'(per0), pv[0], lk[0], lost[0]), pk(m0.period, m0.pv_m, m0.lk_m, m0.lost_m));
      chk("model1", pk(int'(per1), pv[1], lk[1], lost[1]), pk(m1.period, m1.pv_m, m1.lk_m, m1.lost_m));
      chk("model2", pk(int'(per2), pv[2], lk[2], lost[2]), pk(m2.period, m2.pv_m, m2.lk_m, m2.lost_m));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One divided-clock period of p cycles, starting with a rising edge.
  task automatic drive_period(input int k, input int p);
    int h;
    h = p / 2;
    if (h < 1) h = 1;
    cdiv[k] = 1'b1;
    rise_at[(cyc + 3) % RA][k] = 1'b1;
    tick(h);
    cdiv[k] = 1'b0;
    tick(p - h);
  endtask

  function automatic int getp(input int k);
    case (k)
      0:       return int'(per0);
      1:       return int'(per1);
      default: return int'(per2);
    endcase
  endfunction

  task automatic wait_pv(input int k, output bit got, output int p, output bit l, output int c);
    got = 1'b0; p = 0; l = 1'b0; c = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pv[k]) begin
        got = 1'b1; p = getp(k); l = lk[k]; c = cyc;
        return;
      end
    end
  endtask

  typedef struct {
    int k;
    int p;
    int ep;
    bit el;
  } vec_t;

  vec_t tab [0:14];

  function automatic vec_t row(input int k, input int p, input int ep, input bit el);
    vec_t v;
    v = '{k: k, p: p, ep: ep, el: el};
    return v;
  endfunction

  // Drive rows lo..hi on one monitor (plus a closing edge) and compare each
  // reported period, lock flag and pulse spacing.
  task automatic run_table(input int lo, input int hi);
    int k;
    k = tab[lo].k;
    fork
      begin
        for (int i = lo; i <= hi; i++) drive_period(k, tab[i].p);
        drive_period(k, 4);
      end
      begin
        for (int i = lo; i <= hi; i++) begin
          bit g, l;
          int p, c;
          wait_pv(k, g, p, l, c);
          if (!g) chk($sformatf("tab%0d_pv_wait", i), 0, 1);
          else begin
            chk($sformatf("tab%0d_period", i), p, tab[i].ep);
            chk($sformatf("tab%0d_locked", i), int'(l), int'(tab[i].el));
            if (i > lo) chk($sformatf("tab%0d_pv_gap", i), c - last_pv, tab[i].p);
            last_pv = c;
          end
        end
      end
    join
  endtask

  function automatic int pick();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55) return 4;
    if (r < 70) return (r % 2 == 1) ? 3 : 5;
    if (r < 85) return $urandom_range(2, 9);
    if (r < 93) return $urandom_range(62, 66);
    return $urandom_range(10, 40);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lc, t_end;
    bit seen;

    tab[0]  = row(0, 4, 4, 0);
    tab[1]  = row(0, 4, 4, 0);
    tab[2]  = row(0, 4, 4, 0);
    tab[3]  = row(0, 4, 4, 1);
    tab[4]  = row(0, 6, 6, 0);
    tab[5]  = row(0, 4, 4, 0);
    tab[6]  = row(0, 4, 4, 0);
    tab[7]  = row(0, 4, 4, 0);
    tab[8]  = row(0, 4, 4, 1);
    tab[9]  = row(1, 3, 3, 0);
    tab[10] = row(1, 5, 5, 0);
    tab[11] = row(1, 3, 3, 0);
    tab[12] = row(1, 5, 5, 1);
    tab[13] = row(2, 4, 4, 0);
    tab[14] = row(2, 30, 15, 0);

    tick(4);
    chk_on = 1'b1;
    rst_n  = 1'b1;
    chk("reset_state0", pk(int'(per0), pv[0], lk[0], lost[0]), 0);
    chk("reset_state1", pk(int'(per1), pv[1], lk[1], lost[1]), 0);
    chk("reset_state2", pk(int'(per2), pv[2], lk[2], lost[2]), 0);
    tick(2);

    // Divide-by-4 lock, a stretched period, then re-lock.
    run_table(0, 8);

    // Divided clock stops: lost exactly TIMEOUT cycles after the last rise.
    lc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (lost[0]) begin lc = cyc; break; end
    end
    if (lc < 0) chk("lost_wait", 0, 1);
    else begin
      chk("lost_delay", lc - last_pv, TO);
      chk("lost_unlocked", int'(lk[0]), 0);
    end
    tick(1);
    seen = 1'b0;
    fork
      drive_period(0, 4);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (pv[0]) seen = 1'b1;
      end
    join
    chk("no_pv_after_lost", int'(seen), 0);
    chk("lost_cleared", int'(lost[0]), 0);

    // Re-lock, then reset asynchronously in the middle of a period.
    tick(1);
    repeat (5) drive_period(0, 4);
    tick(1);
    chk("locked_before_rst", int'(lk[0]), 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_outputs", pk(int'(per0), pv[0], lk[0], lost[0]), 0);
    tick(3);
    rst_n = 1'b1;
    tick(4);
    fork
      begin drive_period(0, 4); drive_period(0, 4); drive_period(0, 4); end
      begin
        bit g, l;
        int p, c;
        wait_pv(0, g, p, l, c);
        if (!g) chk("post_rst_pv_wait", 0, 1);
        else begin
          chk("post_rst_period", p, 4);
          chk("post_rst_locked", int'(l), 0);
        end
      end
    join

    // Tolerance 1 with alternating 3/5 periods.
    run_table(9, 12);

    // Narrow counter: saturates and never times out.
    tick(80);
    chk("cntw4_no_lost", int'(lost[2]), 0);
    chk("tol1_idle_lost", int'(lost[1]), 1);
    run_table(13, 14);

    // Randomized periods on all three monitors, checked by the model.
    t_end = cyc + 3000;
    fork
      while (cyc < t_end) drive_period(0, pick());
      while (cyc < t_end) drive_period(1, pick());
      while (cyc < t_end) drive_period(2, pick());
    join
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
